// File: rtl/uart_apb_master.sv
// APB master that initialises a CoreUARTapb slave, polls its status and bridges two byte streams.
// Optional macro UART_APB_MASTER_ERR_CNT_EN adds saturating per-error-type counters.
module uart_apb_master #(
  parameter logic [12:0] BAUD_VALUE = 13'd0,
  parameter bit          PRG_BIT8   = 1'b1,
  parameter logic [1:0]  PRG_PARITY = 2'd0,
  parameter logic [2:0]  BAUD_FRCTN = 3'd0,
  parameter bit          FRCTN_WR   = 1'b0,
  parameter bit          FIXEDMODE  = 1'b0
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  output logic [4:0] PADDR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       init_done,
  input  logic       err_clr,
  output logic       parity_err,
  output logic       overflow,
  output logic       framing_err,
  output logic       apb_err
`ifdef UART_APB_MASTER_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt_par,
  output logic [7:0] err_cnt_ovf,
  output logic [7:0] err_cnt_frm
`endif
);

  typedef enum logic [2:0] {INIT_C1, INIT_C2, INIT_FR, POLL, RD_RX, WR_TX} state_e;
  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_e;

  localparam state_e RESET_STATE = FIXEDMODE ? POLL : INIT_C1;
  localparam logic [7:0] CFG_BYTE = {BAUD_VALUE[12:8], PRG_PARITY == 2'd1,
                                     PRG_PARITY != 2'd0, PRG_BIT8};

  state_e     state_q, state_d;
  phase_e     phase_q, phase_d;
  logic       init_done_q, init_done_d;
  logic       full_q, full_d;
  logic [7:0] hold_q, hold_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       par_q, par_d, ovf_q, ovf_d, frm_q, frm_d, apb_q, apb_d;
  logic       complete, poll_done, tx_accept;
  logic [4:0] xfer_addr;
  logic       xfer_wr;
  logic [7:0] xfer_wdata;

  function automatic logic [7:0] sat_inc(input logic [7:0] c, input logic en);
    return (en && c != 8'hFF) ? c + 8'd1 : c;
  endfunction

  assign complete  = (phase_q == PH_ACCESS) && PREADY;
  assign poll_done = complete && (state_q == POLL);
  assign tx_ready  = init_done_q && !full_q;
  assign tx_accept = tx_valid && tx_ready;

  always_comb begin
    xfer_addr  = 5'h10;
    xfer_wr    = 1'b0;
    xfer_wdata = 8'h00;
    case (state_q)
      INIT_C1: begin xfer_addr = 5'h08; xfer_wr = 1'b1; xfer_wdata = BAUD_VALUE[7:0]; end
      INIT_C2: begin xfer_addr = 5'h0C; xfer_wr = 1'b1; xfer_wdata = CFG_BYTE; end
      INIT_FR: begin xfer_addr = 5'h14; xfer_wr = 1'b1; xfer_wdata = {5'b0, BAUD_FRCTN}; end
      RD_RX:   xfer_addr = 5'h04;
      WR_TX:   begin xfer_addr = 5'h00; xfer_wr = 1'b1; xfer_wdata = hold_q; end
      default: ;
    endcase
  end

  // Bus outputs are decoded from flops so reset forces them idle immediately.
  assign PSEL    = (phase_q != PH_IDLE);
  assign PENABLE = (phase_q == PH_ACCESS);
  assign PADDR   = PSEL ? xfer_addr : 5'h00;
  assign PWRITE  = PSEL && xfer_wr;
  assign PWDATA  = PSEL ? xfer_wdata : 8'h00;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    init_done_d = init_done_q || FIXEDMODE;
    case (phase_q)
      PH_IDLE:   phase_d = PH_SETUP;
      PH_SETUP:  phase_d = PH_ACCESS;
      PH_ACCESS: if (PREADY) phase_d = PH_SETUP;
      default:   phase_d = PH_IDLE;
    endcase
    if (complete) begin
      case (state_q)
        INIT_C1: state_d = INIT_C2;
        INIT_C2: begin
          if (FRCTN_WR) begin
            state_d = INIT_FR;
          end else begin
            state_d     = POLL;
            init_done_d = 1'b1;
          end
        end
        INIT_FR: begin
          state_d     = POLL;
          init_done_d = 1'b1;
        end
        // RX is served first so received bytes are not left waiting behind TX.
        POLL: begin
          if (PRDATA[1] && !rx_valid_q)  state_d = RD_RX;
          else if (PRDATA[0] && full_q)  state_d = WR_TX;
          else                           state_d = POLL;
        end
        default: state_d = POLL;
      endcase
    end
  end

  always_comb begin
    full_d     = full_q;
    hold_d     = hold_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    if (tx_accept) begin
      full_d = 1'b1;
      hold_d = tx_data;
    end
    if (complete && state_q == WR_TX) full_d = 1'b0;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (complete && state_q == RD_RX) begin
      rx_valid_d = 1'b1;
      rx_data_d  = PRDATA;
    end
    par_d = err_clr ? 1'b0 : (par_q || (poll_done && PRDATA[2]));
    ovf_d = err_clr ? 1'b0 : (ovf_q || (poll_done && PRDATA[3]));
    frm_d = err_clr ? 1'b0 : (frm_q || (poll_done && PRDATA[4]));
    apb_d = err_clr ? 1'b0 : (apb_q || (complete && PSLVERR));
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q     <= RESET_STATE;
      phase_q     <= PH_IDLE;
      init_done_q <= 1'b0;
      full_q      <= 1'b0;
      hold_q      <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      par_q       <= 1'b0;
      ovf_q       <= 1'b0;
      frm_q       <= 1'b0;
      apb_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      init_done_q <= init_done_d;
      full_q      <= full_d;
      hold_q      <= hold_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      par_q       <= par_d;
      ovf_q       <= ovf_d;
      frm_q       <= frm_d;
      apb_q       <= apb_d;
    end
  end

  assign init_done   = init_done_q;
  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign parity_err  = par_q;
  assign overflow    = ovf_q;
  assign framing_err = frm_q;
  assign apb_err     = apb_q;

`ifdef UART_APB_MASTER_ERR_CNT_EN
  logic [7:0] cnt_par_q, cnt_par_d, cnt_ovf_q, cnt_ovf_d, cnt_frm_q, cnt_frm_d;

  always_comb begin
    cnt_par_d = err_clr ? 8'h00 : sat_inc(cnt_par_q, poll_done && PRDATA[2]);
    cnt_ovf_d = err_clr ? 8'h00 : sat_inc(cnt_ovf_q, poll_done && PRDATA[3]);
    cnt_frm_d = err_clr ? 8'h00 : sat_inc(cnt_frm_q, poll_done && PRDATA[4]);
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      cnt_par_q <= 8'h00;
      cnt_ovf_q <= 8'h00;
      cnt_frm_q <= 8'h00;
    end else begin
      cnt_par_q <= cnt_par_d;
      cnt_ovf_q <= cnt_ovf_d;
      cnt_frm_q <= cnt_frm_d;
    end
  end

  assign err_cnt_par = cnt_par_q;
  assign err_cnt_ovf = cnt_ovf_q;
  assign err_cnt_frm = cnt_frm_q;
`endif

endmodule

// File: tb/tb_uart_apb_master.sv
// Randomised bench for uart_apb_master: a slave model answers every transfer and a
// transaction-level model predicts the next bus access, stream handshakes and sticky flags.
module tb_uart_apb_master;
  logic       PCLK = 1'b0;
  logic       PRESETN = 1'b0;
  logic [4:0] PADDR;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA = 8'h00;
  logic       PREADY = 1'b0;
  logic       PSLVERR = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       init_done;
  logic       err_clr = 1'b0;
  logic       parity_err, overflow, framing_err, apb_err;
`ifdef UART_APB_MASTER_ERR_CNT_EN
  logic [7:0] err_cnt_par, err_cnt_ovf, err_cnt_frm;
`endif

  uart_apb_master #(
    .BAUD_VALUE(13'h145), .PRG_BIT8(1'b1), .PRG_PARITY(2'd1),
    .BAUD_FRCTN(3'd0), .FRCTN_WR(1'b0), .FIXEDMODE(1'b0)
  ) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .init_done(init_done), .err_clr(err_clr), .parity_err(parity_err),
    .overflow(overflow), .framing_err(framing_err), .apb_err(apb_err)
`ifdef UART_APB_MASTER_ERR_CNT_EN
    , .err_cnt_par(err_cnt_par), .err_cnt_ovf(err_cnt_ovf), .err_cnt_frm(err_cnt_frm)
`endif
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: which access comes next and what the stream/flag state should be.
  typedef enum int {K_I1, K_I2, K_POLL, K_RD, K_WR} kind_t;
  kind_t      m_next = K_I1;
  bit         m_init = 1'b0, m_full = 1'b0, m_rxpend = 1'b0;
  logic [7:0] m_txbyte = 8'h00, m_rxbyte = 8'h00;
  logic [3:0] m_flags = 4'h0;
  int         last_cmp = -1;
`ifdef UART_APB_MASTER_ERR_CNT_EN
  int m_cnt [3];
`endif

  task automatic model_reset();
    m_next = K_I1; m_init = 1'b0; m_full = 1'b0; m_rxpend = 1'b0;
    m_flags = 4'h0; last_cmp = -1;
`ifdef UART_APB_MASTER_ERR_CNT_EN
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
`endif
  endtask

  task automatic check_flags(input string tag);
    chk(tag, {apb_err, framing_err, overflow, parity_err}, m_flags);
`ifdef UART_APB_MASTER_ERR_CNT_EN
    chk({tag, "_cpar"}, err_cnt_par, m_cnt[0]);
    chk({tag, "_covf"}, err_cnt_ovf, m_cnt[1]);
    chk({tag, "_cfrm"}, err_cnt_frm, m_cnt[2]);
`endif
  endtask

  task automatic do_reset();
    PRESETN = 1'b0;
    PREADY = 1'b0; tx_valid = 1'b0; err_clr = 1'b0;
    model_reset();
    #1;
    chk("rst_bus", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 16'h0000);
    chk("rst_stream", {tx_ready, rx_valid, init_done, rx_data}, 11'h000);
    check_flags("rst_flags");
    repeat (3) @(negedge PCLK);
    PRESETN = 1'b1;
  endtask

  // One complete APB transfer as seen by the slave, with stream stimulus during its SETUP cycle.
  task automatic do_xfer(input int waits, input logic [7:0] stat, input logic [7:0] rxd,
                         input bit offer, input logic [7:0] obyte, input bit rrdy,
                         input bit clr, input bit slverr);
    logic [4:0] a, ea;
    logic       w, ew;
    logic [7:0] wd, ewd;
    int         n, t0;
    n = 0;
    @(negedge PCLK);
    while (!(PSEL && !PENABLE) && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    chk("setup_seen", n < 50, 1'b1);
    if (n >= 50) return;
    if (last_cmp >= 0) chk("no_idle", cyc - last_cmp, 0);
    a = PADDR; w = PWRITE; wd = PWDATA; t0 = cyc;
    ea = 5'h10; ew = 1'b0; ewd = 8'h00;
    case (m_next)
      K_I1:    begin ea = 5'h08; ew = 1'b1; ewd = 8'h45; end
      K_I2:    begin ea = 5'h0C; ew = 1'b1; ewd = 8'h0F; end
      K_RD:    ea = 5'h04;
      K_WR:    begin ea = 5'h00; ew = 1'b1; ewd = m_txbyte; end
      default: ;
    endcase
    chk("addr", a, ea);
    chk("write", w, ew);
    if (ew) chk("wdata", wd, ewd);
    chk("init_done", init_done, m_init);
    chk("tx_ready", tx_ready, m_init && !m_full);
    chk("rx_valid", rx_valid, m_rxpend);
    if (m_rxpend) chk("rx_data", rx_data, m_rxbyte);

    tx_valid = offer; tx_data = obyte; rx_ready = rrdy; err_clr = clr;
    if (offer && m_init && !m_full) begin m_full = 1'b1; m_txbyte = obyte; end
    if (m_rxpend && rrdy) m_rxpend = 1'b0;
    if (clr) begin
      m_flags = 4'h0;
`ifdef UART_APB_MASTER_ERR_CNT_EN
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
`endif
    end

    @(negedge PCLK);
    tx_valid = 1'b0; err_clr = 1'b0;
    chk("access", {PSEL, PENABLE}, 2'b11);
    chk("tx_ready_acc", tx_ready, m_init && !m_full);
    chk("rx_valid_acc", rx_valid, m_rxpend);
    check_flags("flags_acc");
    for (int i = 0; i < waits; i++) begin
      PREADY = 1'b0;
      @(negedge PCLK);
      chk("hold", {PSEL, PENABLE, PADDR, PWRITE, PWDATA}, {2'b11, a, w, wd});
    end
    PREADY = 1'b1; PSLVERR = slverr;
    PRDATA = (a == 5'h10) ? stat : ((a == 5'h04) ? rxd : 8'h00);
    @(posedge PCLK);
    #1;
    PREADY = 1'b0; PSLVERR = 1'b0;
    chk("latency", cyc - t0, waits + 2);
    last_cmp = cyc;

    if (slverr) m_flags[3] = 1'b1;
    case (m_next)
      K_I1: m_next = K_I2;
      K_I2: begin m_init = 1'b1; m_next = K_POLL; end
      K_POLL: begin
        m_flags[2:0] = m_flags[2:0] | {stat[4], stat[3], stat[2]};
`ifdef UART_APB_MASTER_ERR_CNT_EN
        for (int i = 0; i < 3; i++)
          if (stat[2+i] && m_cnt[i] < 255) m_cnt[i]++;
`endif
        if (stat[1] && !m_rxpend)    m_next = K_RD;
        else if (stat[0] && m_full)  m_next = K_WR;
        else                         m_next = K_POLL;
      end
      K_RD: begin m_rxpend = 1'b1; m_rxbyte = rxd; m_next = K_POLL; end
      default: begin m_full = 1'b0; m_next = K_POLL; end
    endcase
    check_flags("flags_cmp");
  endtask

  task automatic to_poll();
    for (int i = 0; i < 4 && m_next != K_POLL; i++)
      do_xfer(0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    do_reset();
    // Init writes with zero wait states, TX offered but not accepted yet.
    do_xfer(0, 8'h00, 8'h00, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    do_xfer(0, 8'h00, 8'h00, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
    // RX path: status RXRDY, then data A5 consumed with rx_ready high.
    do_xfer(0, 8'h02, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    do_xfer(0, 8'h00, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    do_xfer(0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    // TX path: accept 3C, TXRDY, write with three wait states.
    do_xfer(0, 8'h00, 8'h00, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    do_xfer(0, 8'h01, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    do_xfer(3, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    // RX beats TX when both ready.
    do_xfer(0, 8'h00, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    do_xfer(0, 8'h03, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    do_xfer(0, 8'h00, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    // Consumer stalled: RXRDY must not trigger another data read.
    do_xfer(1, 8'h02, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    do_xfer(0, 8'h02, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    to_poll();
    // Error flags set then cleared.
    do_xfer(0, 8'h1C, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    to_poll();
    do_xfer(0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    for (int it = 0; it < 400; it++) begin
      logic [7:0] st;
      st = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) st = st | (8'($urandom) & 8'h1C);
      do_xfer($urandom_range(0, 3), st, 8'($urandom), $urandom_range(0, 1) == 1,
              8'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 15) == 0);
    end

    // Abort a TX write mid-access with reset.
    to_poll();
    do_xfer(0, 8'h00, 8'h00, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    do_xfer(0, 8'h01, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    to_poll();
    do_xfer(0, 8'h01, 8'h00, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    n = 0;
    @(negedge PCLK);
    while (!(PSEL && !PENABLE) && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    @(negedge PCLK);
    chk("abort_access", {PSEL, PENABLE, PADDR, PWRITE}, {2'b11, 5'h00, 1'b1});
    do_reset();
    do_xfer(0, 8'h00, 8'h00, 1'b1, 8'hE1, 1'b1, 1'b0, 1'b0);
    do_xfer(2, 8'h00, 8'h00, 1'b1, 8'hE2, 1'b1, 1'b0, 1'b0);
    do_xfer(0, 8'h01, 8'h00, 1'b1, 8'hE3, 1'b1, 1'b0, 1'b0);
    do_xfer(0, 8'h01, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    do_xfer(0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
